// File: rtl/tx_pkg.sv
// tx_pkg: shared FSM state type and Ethernet framing constants for the TX frame sequencer
package tx_pkg;
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, GAP} tx_state_e;
  localparam int ETH_HDR_BYTES = 14;
  localparam int ETH_MIN_PAYLOAD = 46;
  localparam int ETH_MAX_PAYLOAD = 1500;
  localparam int ETH_IFG_CYCLES = 12;
endpackage

// File: rtl/tx_byte_counter.sv
// tx_byte_counter: per-frame byte index with header-end and frame-end compares
// ports: clk, rst (async, high); inc advances, clr zeroes (wins over inc);
//        len = clamped payload length; count = current byte index;
//        hdr_last / frame_last flag the final header / final frame byte
module tx_byte_counter import tx_pkg::*; #(
  parameter int HDR_BYTES = ETH_HDR_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clr,
  input  logic [15:0] len,
  output logic [15:0] count,
  output logic        hdr_last,
  output logic        frame_last
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 16'd1;
  assign hdr_last = count == 16'(HDR_BYTES - 1);
  assign frame_last = count == 16'(HDR_BYTES) + len - 16'd1;
endmodule

// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: sequences Ethernet frames (header, counting payload, gap) onto a MAC TX AXIS port
// ports: clk, rst (async, high); enable starts/continues runs;
//        dest_addr/src_addr/payload_len sampled per frame, frame_count per run (0 = endless);
//        tx_axis_* = AXIS byte stream to the MAC; busy = not idle;
//        frames_sent = frames done this run; done = 1-cycle end-of-run pulse
module tx_frame_sequencer import tx_pkg::*; #(
  parameter int HDR_BYTES = ETH_HDR_BYTES,
  parameter int MIN_PAYLOAD = ETH_MIN_PAYLOAD,
  parameter int MAX_PAYLOAD = ETH_MAX_PAYLOAD,
  parameter int IFG_CYCLES = ETH_IFG_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [47:0] dest_addr,
  input  logic [47:0] src_addr,
  input  logic [15:0] payload_len,
  input  logic [15:0] frame_count,
  output logic [7:0]  tx_axis_tdata,
  output logic        tx_axis_tvalid,
  output logic        tx_axis_tlast,
  input  logic        tx_axis_tready,
  output logic        busy,
  output logic [15:0] frames_sent,
  output logic        done
);
  tx_state_e state;
  logic [47:0] da, sa;
  logic [15:0] len, fc, count, nxt, clamp_len, ifg;
  logic hdr_last, frame_last, beat, ifg_end, run_done, start;
  assign beat = tx_axis_tvalid & tx_axis_tready;
  assign nxt = count + 16'd1;
  assign clamp_len = payload_len < 16'(MIN_PAYLOAD) ? 16'(MIN_PAYLOAD) :
                     payload_len > 16'(MAX_PAYLOAD) ? 16'(MAX_PAYLOAD) : payload_len;
  assign ifg_end = ifg == 16'(IFG_CYCLES - 1);
  assign run_done = fc != 16'd0 && frames_sent == fc;
  // a frame starts from IDLE, or straight out of the gap when the run continues
  assign start = enable && (state == IDLE || (state == GAP && ifg_end && !run_done));
  tx_byte_counter #(.HDR_BYTES(HDR_BYTES)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(beat),
    .clr(beat & frame_last),
    .len(len),
    .count(count),
    .hdr_last(hdr_last),
    .frame_last(frame_last)
  );
  // byte at index i >= 1; byte 0 comes straight from dest_addr at frame start
  function automatic logic [7:0] byte_at(input logic [15:0] i);
    logic [15:0] k;
    k = i - 16'(HDR_BYTES);
    return i < 16'd6 ? 8'(da >> (8 * (16'd5 - i))) :
           i < 16'd12 ? 8'(sa >> (8 * (16'd11 - i))) :
           i == 16'd12 ? len[15:8] :
           i == 16'd13 ? len[7:0] : k[7:0];
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      da <= '0;
      sa <= '0;
      len <= '0;
      fc <= '0;
      ifg <= '0;
      tx_axis_tdata <= '0;
      tx_axis_tvalid <= 1'b0;
      tx_axis_tlast <= 1'b0;
      busy <= 1'b0;
      frames_sent <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state <= HEADER;
        busy <= 1'b1;
        da <= dest_addr;
        sa <= src_addr;
        len <= clamp_len;
        tx_axis_tdata <= dest_addr[47:40];
        tx_axis_tvalid <= 1'b1;
        tx_axis_tlast <= 1'b0;
        if (state == IDLE) begin
          fc <= frame_count;
          frames_sent <= '0;
        end
      end else case (state)
        HEADER, PAYLOAD: if (beat) begin
          if (frame_last) begin
            state <= GAP;
            tx_axis_tvalid <= 1'b0;
            tx_axis_tlast <= 1'b0;
            tx_axis_tdata <= '0;
            frames_sent <= frames_sent + 16'd1;
            ifg <= '0;
          end else begin
            state <= hdr_last ? PAYLOAD : state;
            tx_axis_tdata <= byte_at(nxt);
            tx_axis_tlast <= nxt == 16'(HDR_BYTES) + len - 16'd1;
          end
        end
        GAP: if (ifg_end) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= run_done;
        end else ifg <= ifg + 16'd1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_tx_frame_sequencer.sv
// tb_tx_frame_sequencer: randomized self-checking bench against a frame-level reference model
module tb_tx_frame_sequencer;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, tready = 1'b1;
  logic [47:0] dest_addr = '0, src_addr = '0;
  logic [15:0] payload_len = 16'd46, frame_count = 16'd1;
  logic [7:0] tdata;
  logic tvalid, tlast, busy, done;
  logic [15:0] frames_sent;
  int total = 0, bad = 0, stall_pct = 0;
  logic [7:0] exp_q[$];
  int exp_len = 0, idx = 0, done_cnt = 0, last_beats = 0;
  logic in_frame = 0, prev_stall = 0, prev_busy = 0, went_idle = 1, have_prev = 0, prev_last = 0;
  logic [7:0] prev_data = '0;
  logic [15:0] model_sent = '0, run_fc = '0;
  longint cyc = 0, done_due = -1, tlast_cyc = 0;
  always #5 clk = ~clk;
  tx_frame_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .dest_addr(dest_addr), .src_addr(src_addr),
    .payload_len(payload_len), .frame_count(frame_count), .tx_axis_tdata(tdata),
    .tx_axis_tvalid(tvalid), .tx_axis_tlast(tlast), .tx_axis_tready(tready),
    .busy(busy), .frames_sent(frames_sent), .done(done)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic build_frame();
    logic [15:0] l;
    l = payload_len < 16'd46 ? 16'd46 : payload_len > 16'd1500 ? 16'd1500 : payload_len;
    exp_q.delete();
    for (int b = 5; b >= 0; b--) exp_q.push_back(dest_addr[8*b +: 8]);
    for (int b = 5; b >= 0; b--) exp_q.push_back(src_addr[8*b +: 8]);
    exp_q.push_back(l[15:8]);
    exp_q.push_back(l[7:0]);
    for (int k = 0; k < int'(l); k++) exp_q.push_back(8'(k));
    exp_len = exp_q.size();
  endtask
  task automatic monitor();
    cyc++;
    if (rst) begin
      in_frame = 0;
      idx = 0;
      prev_stall = 0;
      prev_busy = 0;
      model_sent = '0;
      done_due = -1;
      went_idle = 1;
      have_prev = 0;
      return;
    end
    if (busy && !prev_busy) begin
      model_sent = '0;
      run_fc = frame_count;
    end
    prev_busy = busy;
    if (!busy) went_idle = 1;
    check("frames_sent", frames_sent, model_sent);
    check("done", done, cyc == done_due);
    if (done) done_cnt++;
    if (prev_stall) begin
      check("hold_data", tdata, prev_data);
      check("hold_last", tlast, prev_last);
    end
    if (tvalid && !in_frame) begin
      build_frame();
      in_frame = 1;
      idx = 0;
      if (!went_idle && have_prev) check("ifg", cyc - tlast_cyc - 1, 12);
    end
    if (in_frame) check("no_bubble", tvalid, 1);
    if (!tvalid) check("tlast_idle", tlast, 0);
    if (tvalid && tready) begin
      check("data", tdata, exp_q[idx]);
      check("last", tlast, idx == exp_len - 1);
      idx++;
      if (idx == exp_len) begin
        in_frame = 0;
        last_beats = idx;
        tlast_cyc = cyc;
        have_prev = 1;
        went_idle = 0;
        model_sent++;
        if (run_fc != 0 && model_sent == run_fc) done_due = cyc + 13;
      end
    end
    prev_stall = tvalid && !tready;
    prev_data = tdata;
    prev_last = tlast;
  endtask
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    tready = $urandom_range(99) >= stall_pct;
  endtask
  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      cycle();
      n++;
    end
    check("idle_reached", busy, 0);
  endtask
  task automatic run_frames(input logic [15:0] plen, input logic [15:0] fc, input int pct);
    int n = 0;
    int d0 = done_cnt;
    dest_addr = 48'({$urandom(), $urandom()});
    src_addr = 48'({$urandom(), $urandom()});
    payload_len = plen;
    frame_count = fc;
    stall_pct = pct;
    enable = 1;
    cycle();
    while (!done && n < 20000) begin
      cycle();
      n++;
    end
    enable = 0;
    check("run_done", done, 1);
    check("run_count", frames_sent, fc);
    wait_idle(100);
    cycle();
    cycle();
    check("done_once", done_cnt - d0, 1);
  endtask
  initial begin
    int n;
    int d0;
    #1 rst = 1;
    repeat (3) cycle();
    check("rst_tdata", tdata, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_sent", frames_sent, 0);
    check("rst_done", done, 0);
    rst = 0;
    repeat (3) cycle();
    check("idle_valid", tvalid, 0);
    run_frames(16'd46, 16'd1, 0);
    check("t1_beats", last_beats, 60);
    run_frames(16'd10, 16'd1, 0);
    check("t2_min_beats", last_beats, 60);
    run_frames(16'd2000, 16'd1, 0);
    check("t2_max_beats", last_beats, 1514);
    run_frames(16'd100, 16'd1, 50);
    check("t3_beats", last_beats, 114);
    run_frames(16'd46, 16'd3, 0);
    check("t4_sent", frames_sent, 3);
    d0 = done_cnt;
    dest_addr = 48'({$urandom(), $urandom()});
    payload_len = 16'd60;
    frame_count = 16'd0;
    stall_pct = 25;
    enable = 1;
    n = 0;
    while (!(frames_sent == 16'd1 && in_frame && idx >= 20) && n < 5000) begin
      cycle();
      n++;
    end
    check("t5_mid", frames_sent, 1);
    enable = 0;
    dest_addr = 48'({$urandom(), $urandom()});
    src_addr = 48'({$urandom(), $urandom()});
    payload_len = 16'($urandom_range(46, 200));
    wait_idle(5000);
    repeat (20) cycle();
    check("t5_sent", frames_sent, 2);
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_busy", busy, 0);
    dest_addr = 48'({$urandom(), $urandom()});
    payload_len = 16'd80;
    stall_pct = 0;
    enable = 1;
    n = 0;
    while (!(in_frame && idx == 30 && tvalid) && n < 3000) begin
      cycle();
      n++;
    end
    check("t6_reached", idx, 30);
    rst = 1;
    #1;
    check("t6_tvalid", tvalid, 0);
    check("t6_tlast", tlast, 0);
    check("t6_busy", busy, 0);
    check("t6_sent", frames_sent, 0);
    repeat (2) cycle();
    rst = 0;
    cycle();
    check("t6_restart_valid", tvalid, 1);
    check("t6_restart_da0", tdata, dest_addr[47:40]);
    n = 0;
    while (frames_sent != 16'd1 && n < 3000) begin
      cycle();
      n++;
    end
    enable = 0;
    wait_idle(200);
    for (int r = 0; r < 6; r++)
      run_frames(16'($urandom_range(0, 220)), 16'($urandom_range(1, 3)), $urandom_range(0, 60));
    repeat (5) cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
